// File: rtl/gyro_link_pkg.sv
// Shared constants and types for the gyro telemetry UART link:
// frame geometry, filler/sync values, staging byte slots and state encodings.
package gyro_link_pkg;

    localparam int         FRAME_LEN = 12;
    localparam int         DATA_LEN  = 6;
    localparam logic [7:0] FILLER    = 8'h55;
    localparam int         SYNC_LEN  = 6;

    localparam logic [2:0] IDX_X_LO = 3'd0;
    localparam logic [2:0] IDX_X_HI = 3'd1;
    localparam logic [2:0] IDX_Y_LO = 3'd2;
    localparam logic [2:0] IDX_Y_HI = 3'd3;
    localparam logic [2:0] IDX_Z_LO = 3'd4;
    localparam logic [2:0] IDX_Z_HI = 3'd5;
    localparam logic [3:0] IDX_LAST = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        DEC_HUNT = 2'd0,
        DEC_DATA = 2'd1,
        DEC_FILL = 2'd2
    } dec_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    function automatic logic [15:0] join_bytes(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchronizer, start-edge detection, mid-bit sampling.
// Emits one-cycle data/valid on a good stop bit, err on a low stop bit.
module uart_rx_byte
    import gyro_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;
    logic [1:0]       warm_r;
    logic             fall_s;

    rx_state_t        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_r, bit_s;
    logic [7:0]       shift_r, shift_s;
    logic [7:0]       data_s;
    logic             valid_s;
    logic             err_s;

    // Synchronizer; prev only tracks the line once the chain holds real samples,
    // so a line held low through reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b0;
            warm_r  <= 2'd0;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            prev_r  <= (warm_r == 2'd2) ? sync2_r : 1'b0;
            if (warm_r != 2'd2) begin
                warm_r <= warm_r + 2'd1;
            end else begin
                warm_r <= warm_r;
            end
        end
    end

    assign fall_s = prev_r & ~sync2_r;

    // Receiver next-state: counters expire at 1 so the load value equals the wait length.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        data_s  = data;
        valid_s = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (fall_s) begin
                    state_s = RX_START;
                    cnt_s   = HALF_BIT;
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == CNT_ONE) begin
                    if (!sync2_r) begin
                        state_s = RX_DATA;
                        cnt_s   = FULL_BIT;
                        bit_s   = 3'd0;
                    end else begin
                        state_s = RX_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_r == CNT_ONE) begin
                    shift_s = {sync2_r, shift_r[7:1]};
                    cnt_s   = FULL_BIT;
                    if (bit_r == 3'd7) begin
                        state_s = RX_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_r == CNT_ONE) begin
                    if (sync2_r) begin
                        data_s  = shift_r;
                        valid_s = 1'b1;
                        state_s = RX_IDLE;
                    end else begin
                        err_s   = 1'b1;
                        state_s = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_r) begin
                    state_s = RX_IDLE;
                end else begin
                    state_s = RX_WAIT_HIGH;
                end
            end
            default: begin
                state_s = RX_IDLE;
            end
        endcase
    end

    // Receiver state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RX_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            data    <= 8'h00;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            data    <= data_s;
            valid   <= valid_s;
            err     <= err_s;
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Gyro telemetry receive end: locks onto the filler run, stages six data bytes,
// verifies the six trailing fillers and commits x/y/z together.
module uart_frame_rx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] FILLER       = gyro_link_pkg::FILLER,
    parameter int         SYNC_LEN     = gyro_link_pkg::SYNC_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] x_axis,
    output logic [15:0] y_axis,
    output logic [15:0] z_axis,
    output logic        frame_valid,
    output logic        locked,
    output logic        frame_err,
    output logic        rx_err,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid
);

    import gyro_link_pkg::*;

    localparam int RUN_W = $clog2(SYNC_LEN + 1);

    logic [7:0]       byte_s;
    logic             byte_valid_s;
    logic             byte_err_s;

    dec_state_t       dec_r, dec_s;
    logic [3:0]       idx_r, idx_s;
    logic [RUN_W-1:0] run_r, run_s;
    logic             locked_r, locked_s;
    logic [7:0]       stage_r [DATA_LEN];
    logic [7:0]       stage_s [DATA_LEN];
    logic             commit_s;
    logic             ferr_s;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .data  (byte_s),
        .valid (byte_valid_s),
        .err   (byte_err_s)
    );

    assign rx_byte       = byte_s;
    assign rx_byte_valid = byte_valid_s;
    assign rx_err        = byte_err_s;
    assign locked        = locked_r;

    // Frame decoder next-state; a line error always drops back to hunting.
    always_comb begin
        dec_s    = dec_r;
        idx_s    = idx_r;
        run_s    = run_r;
        locked_s = locked_r;
        commit_s = 1'b0;
        ferr_s   = 1'b0;
        for (int i = 0; i < DATA_LEN; i++) begin
            stage_s[i] = stage_r[i];
        end
        if (byte_err_s) begin
            if (dec_r != DEC_HUNT) begin
                ferr_s = 1'b1;
            end else begin
                ferr_s = 1'b0;
            end
            dec_s    = DEC_HUNT;
            idx_s    = 4'd0;
            run_s    = RUN_W'(0);
            locked_s = 1'b0;
        end else if (byte_valid_s) begin
            case (dec_r)
                DEC_HUNT: begin
                    if (byte_s == FILLER) begin
                        if (run_r == RUN_W'(SYNC_LEN - 1)) begin
                            dec_s    = DEC_DATA;
                            idx_s    = 4'd0;
                            run_s    = RUN_W'(0);
                            locked_s = 1'b1;
                        end else begin
                            run_s = run_r + RUN_W'(1);
                        end
                    end else begin
                        run_s = RUN_W'(0);
                    end
                end
                DEC_DATA: begin
                    stage_s[idx_r[2:0]] = byte_s;
                    idx_s = idx_r + 4'd1;
                    if (idx_r == 4'(DATA_LEN - 1)) begin
                        dec_s = DEC_FILL;
                    end else begin
                        dec_s = DEC_DATA;
                    end
                end
                DEC_FILL: begin
                    if (byte_s != FILLER) begin
                        ferr_s   = 1'b1;
                        dec_s    = DEC_HUNT;
                        idx_s    = 4'd0;
                        run_s    = RUN_W'(0);
                        locked_s = 1'b0;
                    end else if (idx_r == IDX_LAST) begin
                        commit_s = 1'b1;
                        dec_s    = DEC_DATA;
                        idx_s    = 4'd0;
                    end else begin
                        idx_s = idx_r + 4'd1;
                    end
                end
                default: begin
                    dec_s    = DEC_HUNT;
                    idx_s    = 4'd0;
                    run_s    = RUN_W'(0);
                    locked_s = 1'b0;
                end
            endcase
        end else begin
            dec_s = dec_r;
        end
    end

    // Decoder registers; reset discards any partially staged frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_r       <= DEC_HUNT;
            idx_r       <= 4'd0;
            run_r       <= RUN_W'(0);
            locked_r    <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            x_axis      <= 16'h0000;
            y_axis      <= 16'h0000;
            z_axis      <= 16'h0000;
            for (int i = 0; i < DATA_LEN; i++) begin
                stage_r[i] <= 8'h00;
            end
        end else begin
            dec_r       <= dec_s;
            idx_r       <= idx_s;
            run_r       <= run_s;
            locked_r    <= locked_s;
            frame_valid <= commit_s;
            frame_err   <= ferr_s;
            for (int i = 0; i < DATA_LEN; i++) begin
                stage_r[i] <= stage_s[i];
            end
            if (commit_s) begin
                x_axis <= join_bytes(stage_r[IDX_X_LO], stage_r[IDX_X_HI]);
                y_axis <= join_bytes(stage_r[IDX_Y_LO], stage_r[IDX_Y_HI]);
                z_axis <= join_bytes(stage_r[IDX_Z_LO], stage_r[IDX_Z_HI]);
            end else begin
                x_axis <= x_axis;
                y_axis <= y_axis;
                z_axis <= z_axis;
            end
        end
    end

endmodule
